test_sequencer: RTL

Sequences the directed tests of the single-cycle MIPS bench one at a time, and sits directly upstream of the per-test modules. For each test slot it issues a one-cycle start pulse, waits for that test's done/pass handshake (with an optional watchdog), and records the result. It also publishes aggregate pass/fail/timeout counts and an all-done flag for the top-level bench to report.

---
 rtl/test_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/test_sequencer.sv
// test_sequencer: launches directed test slots one at a time, waits for each
// done/pass handshake and tallies the results. Define TEST_SEQ_TIMEOUT_EN for the watchdog.
module test_sequencer #(
    parameter int NUM_TESTS = 16,
    parameter int TIMEOUT   = 1024,
    localparam int IW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int CW = $clog2(NUM_TESTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_TESTS-1:0] test_done,
    input  logic [NUM_TESTS-1:0] test_pass,
    output logic [NUM_TESTS-1:0] test_start,
    output logic                 busy,
    output logic                 all_done,
    output logic [IW-1:0]        current_test,
    output logic [NUM_TESTS-1:0] pass_vec,
    output logic [CW-1:0]        pass_count,
    output logic [CW-1:0]        fail_count,
    output logic [CW-1:0]        timeout_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t               state_reg, state_next;
    logic [IW-1:0]        cur_reg, cur_next;
    logic [NUM_TESTS-1:0] pass_vec_reg, pass_vec_next;
    logic [CW-1:0]        pass_cnt_reg, pass_cnt_next;
    logic [CW-1:0]        fail_cnt_reg, fail_cnt_next;

    logic [NUM_TESTS-1:0] sel_done;
    logic [NUM_TESTS-1:0] sel_pass;
    logic                 done_hit;
    logic                 pass_hit;
    logic                 timed_out;
    logic                 last_test;
    logic                 run_clear;

    // Only the active slot's handshake is visible; all other done bits are masked.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TESTS; gi++) begin : g_slot
            assign sel_done[gi]   = test_done[gi] && (cur_reg == IW'(gi));
            assign sel_pass[gi]   = test_pass[gi] && (cur_reg == IW'(gi));
            assign test_start[gi] = (state_reg == S_LAUNCH) && (cur_reg == IW'(gi));
        end
    endgenerate

    assign done_hit  = (state_reg == S_WAIT) && (|sel_done);
    assign pass_hit  = |(sel_done & sel_pass);
    assign last_test = (cur_reg == IW'(NUM_TESTS - 1));
    assign run_clear = ((state_reg == S_IDLE) || (state_reg == S_FINISH)) && start;

`ifdef TEST_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] timer_reg, timer_next;
    logic [CW-1:0] to_cnt_reg, to_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg  <= '0;
            to_cnt_reg <= '0;
        end else begin
            timer_reg  <= timer_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    // Timer reads 0 in the first WAIT cycle, so expiry lands on the TIMEOUT-th WAIT cycle.
    assign timed_out     = (state_reg == S_WAIT) && (timer_reg == TW'(TIMEOUT - 1));
    assign timeout_count = to_cnt_reg;

    always_comb begin
        timer_next  = timer_reg;
        to_cnt_next = to_cnt_reg;
        if (run_clear) begin
            to_cnt_next = '0;
        end
        if (state_reg == S_LAUNCH) begin
            timer_next = '0;
        end else if ((state_reg == S_WAIT) && !done_hit) begin
            if (timed_out) begin
                to_cnt_next = to_cnt_reg + CW'(1);
            end else begin
                timer_next = timer_reg + TW'(1);
            end
        end
    end
`else
    assign timed_out     = 1'b0;
    assign timeout_count = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cur_reg      <= '0;
            pass_vec_reg <= '0;
            pass_cnt_reg <= '0;
            fail_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cur_reg      <= cur_next;
            pass_vec_reg <= pass_vec_next;
            pass_cnt_reg <= pass_cnt_next;
            fail_cnt_reg <= fail_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        pass_vec_next = pass_vec_reg;
        pass_cnt_next = pass_cnt_reg;
        fail_cnt_next = fail_cnt_reg;
        case (state_reg)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    state_next    = S_LAUNCH;
                    cur_next      = '0;
                    pass_vec_next = '0;
                    pass_cnt_next = '0;
                    fail_cnt_next = '0;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done in the expiry cycle still counts as a real verdict.
                if (done_hit || timed_out) begin
                    if (done_hit && pass_hit) begin
                        pass_cnt_next = pass_cnt_reg + CW'(1);
                        pass_vec_next = pass_vec_reg | sel_pass;
                    end else begin
                        fail_cnt_next = fail_cnt_reg + CW'(1);
                    end
                    if (last_test) begin
                        state_next = S_FINISH;
                    end else begin
                        cur_next   = cur_reg + IW'(1);
                        state_next = S_LAUNCH;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy         = (state_reg == S_LAUNCH) || (state_reg == S_WAIT);
    assign all_done     = (state_reg == S_FINISH);
    assign current_test = cur_reg;
    assign pass_vec     = pass_vec_reg;
    assign pass_count   = pass_cnt_reg;
    assign fail_count   = fail_cnt_reg;

endmodule
